// File: rtl/jedro_1_defines.sv
// Shared bus types and master indices for the jedro-1 data-RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jedro_1_defines;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  // Fixed master slots on the shared data-RAM port.
  localparam int ARB_LSU_IDX = 0;
  localparam int ARB_IFU_IDX = 1;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] data;
    logic [3:0]            strobe;
    logic                  write;
  } bus_req_t;

  typedef struct packed {
    logic [BUS_DATA_W-1:0] data;
    logic                  err;
  } bus_rsp_t;

  // Pointer width that never collapses to zero bits.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jedro_1_id_fifo.sv
// In-order FIFO holding the master ID of each request awaiting its response.
// Latency: push visible at head the cycle after; registered storage, no bypass.
// Backpressure: pushes ignored when full, pops ignored when empty.
module jedro_1_id_fifo
  import jedro_1_defines::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = safe_clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next pointers wrap at DEPTH; count only moves on an unbalanced push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // ID storage; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/jedro_1_bus_arbiter.sv
// Shares the jedro-1 data-RAM port among NUM_MASTERS requesters; responses steered by in-order ID FIFO.
// Latency: zero-cycle request and response paths, 1 transaction/cycle with MAX_OUTSTANDING>=2.
// Backpressure: grant locks while the RAM stalls; requests stall when the ID FIFO is full.
// Option: define JEDRO_1_ARB_ROUND_ROBIN_EN for round-robin priority (default: fixed, LSU highest).
module jedro_1_bus_arbiter
  import jedro_1_defines::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  bus_req_t               m_req_i       [NUM_MASTERS],
  input  logic [NUM_MASTERS-1:0] m_req_valid_i,
  output logic [NUM_MASTERS-1:0] m_req_ready_o,
  output bus_rsp_t               m_rsp_o       [NUM_MASTERS],
  output logic [NUM_MASTERS-1:0] m_rsp_valid_o,
  input  logic [NUM_MASTERS-1:0] m_rsp_ready_i,
  output bus_req_t               s_req_o,
  output logic                   s_req_valid_o,
  input  logic                   s_req_ready_i,
  input  bus_rsp_t               s_rsp_i,
  input  logic                   s_rsp_valid_i,
  output logic                   s_rsp_ready_o,
  output logic                   spurious_rsp_o
);

  localparam int ID_W = $clog2(NUM_MASTERS);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_MASTERS - 1);

  logic            lock_q;
  logic [ID_W-1:0] lock_idx_q;
  logic            spurious_q;
  logic [ID_W-1:0] pick, gnt, head;
  logic            fifo_full, fifo_empty;
  logic            req_vld, req_hs, rsp_hs;

`ifdef JEDRO_1_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_q;
  logic [ID_W-1:0] rr_cand;
  logic            rr_found;
  int              rr_idx;

  // Round-robin pick: first requesting master at or after rr_q.
  always_comb begin
    pick     = '0;
    rr_cand  = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      rr_idx = int'(rr_q) + k;
      if (rr_idx >= NUM_MASTERS) rr_idx = rr_idx - NUM_MASTERS;
      rr_cand = ID_W'(rr_idx);
      if (!rr_found && m_req_valid_i[rr_cand]) begin
        pick     = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  // Rotate priority past the master whose request was just accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i)       rr_q <= '0;
    else if (req_hs) rr_q <= (gnt == LAST_IDX) ? '0 : gnt + 1'b1;
  end
`else
  // Fixed-priority pick: lowest index (LSU) wins.
  always_comb begin
    pick = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (m_req_valid_i[ID_W'(i)]) pick = ID_W'(i);
    end
  end
`endif

  // A stalled request keeps its grant so s_req_o cannot change under the RAM.
  assign gnt     = lock_q ? lock_idx_q : pick;
  assign s_req_o = m_req_i[gnt];
  // Full FIFO stalls regardless of a same-cycle pop: no rsp->req comb path.
  assign req_vld = m_req_valid_i[gnt] & ~fifo_full;
  assign req_hs  = req_vld & s_req_ready_i;
  assign rsp_hs  = s_rsp_valid_i & s_rsp_ready_o & ~fifo_empty;

  assign s_req_valid_o  = req_vld & ~rst_i;
  assign spurious_rsp_o = spurious_q & ~rst_i;
  // With the FIFO empty any response is accepted and dropped.
  assign s_rsp_ready_o  = ~rst_i & (fifo_empty | m_rsp_ready_i[head]);

  // Per-master request ready and response steering by FIFO head.
  always_comb begin
    m_req_ready_o = '0;
    m_rsp_valid_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_rsp_o[i]       = s_rsp_i;
      m_req_ready_o[i] = ~rst_i & (gnt == ID_W'(i)) & s_req_ready_i & ~fifo_full;
      m_rsp_valid_o[i] = ~rst_i & s_rsp_valid_i & ~fifo_empty & (head == ID_W'(i));
    end
  end

  // Lock the grant while the RAM withholds ready; release on the handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (req_hs) begin
      lock_q     <= 1'b0;
    end else if (req_vld && !s_req_ready_i) begin
      lock_q     <= 1'b1;
      lock_idx_q <= gnt;
    end
  end

  // Sticky flag: a response arrived with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i)                            spurious_q <= 1'b0;
    else if (s_rsp_valid_i && fifo_empty) spurious_q <= 1'b1;
  end

  jedro_1_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (req_hs),
    .push_dat_i (gnt),
    .pop_i      (rsp_hs),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

endmodule

// File: tb/tb_jedro_1_bus_arbiter.sv
// Directed self-checking bench for jedro_1_bus_arbiter (2 masters, 2 outstanding).
// Latency: inputs driven 1 ns after posedge, outputs sampled 2 ns after posedge.
// Backpressure: scenarios cover RAM stall, FIFO full and response stall.
module tb_jedro_1_bus_arbiter;
  import jedro_1_defines::*;

  logic       clk = 1'b0;
  logic       rst;
  bus_req_t   m_req [2];
  logic [1:0] m_req_valid, m_req_ready;
  bus_rsp_t   m_rsp [2];
  logic [1:0] m_rsp_valid, m_rsp_ready;
  bus_req_t   s_req;
  logic       s_req_valid, s_req_ready;
  bus_rsp_t   s_rsp;
  logic       s_rsp_valid, s_rsp_ready, spurious;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jedro_1_bus_arbiter #(
    .NUM_MASTERS     (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .m_req_i        (m_req),
    .m_req_valid_i  (m_req_valid),
    .m_req_ready_o  (m_req_ready),
    .m_rsp_o        (m_rsp),
    .m_rsp_valid_o  (m_rsp_valid),
    .m_rsp_ready_i  (m_rsp_ready),
    .s_req_o        (s_req),
    .s_req_valid_o  (s_req_valid),
    .s_req_ready_i  (s_req_ready),
    .s_rsp_i        (s_rsp),
    .s_rsp_valid_i  (s_rsp_valid),
    .s_rsp_ready_o  (s_rsp_ready),
    .spurious_rsp_o (spurious)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_req_valid = 2'b00;
    m_rsp_ready = 2'b00;
    s_req_ready = 1'b0;
    s_rsp_valid = 1'b0;
    s_rsp       = '0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    m_req_valid = 2'b11;
    m_rsp_ready = 2'b11;
    s_req_ready = 1'b1;
    s_rsp_valid = 1'b1;
    tick();
    #1;
    n_checks++; if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_s_req_valid got=%b exp=0", s_req_valid); end
    n_checks++; if (m_req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_m_req_ready got=%b exp=00", m_req_ready); end
    n_checks++; if (m_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_m_rsp_valid got=%b exp=00", m_rsp_valid); end
    n_checks++; if (s_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_rsp_ready got=%b exp=0", s_rsp_ready); end
    n_checks++; if (spurious !== 1'b0) begin n_fail++; $display("FAIL rst_spurious got=%b exp=0", spurious); end
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    // Empty FIFO shows as s_rsp_ready=1 even with no master ready.
    n_checks++; if (s_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL rel_empty got=%b exp=1", s_rsp_ready); end
    n_checks++; if (m_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rel_m_rsp_valid got=%b exp=00", m_rsp_valid); end
    n_checks++; if (spurious !== 1'b0) begin n_fail++; $display("FAIL rel_spurious got=%b exp=0", spurious); end
  endtask

  task automatic test_priority();
    logic [1:0] exp_rdy [3];
    logic [1:0] exp_rsp [3];
    logic [31:0] exp_addr;
`ifdef JEDRO_1_ARB_ROUND_ROBIN_EN
    exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b01;
    exp_rsp[0] = 2'b00; exp_rsp[1] = 2'b01; exp_rsp[2] = 2'b10;
`else
    exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b01; exp_rdy[2] = 2'b01;
    exp_rsp[0] = 2'b00; exp_rsp[1] = 2'b01; exp_rsp[2] = 2'b01;
`endif
    do_reset();
    m_req[0] = '{addr: 32'h10, data: 32'h0, strobe: 4'hF, write: 1'b0};
    m_req[1] = '{addr: 32'h20, data: 32'h0, strobe: 4'hF, write: 1'b0};
    m_req_valid = 2'b11;
    s_req_ready = 1'b1;
    m_rsp_ready = 2'b11;
    s_rsp.data  = 32'h1234;
    for (int c = 0; c < 3; c++) begin
      s_rsp_valid = (c > 0);
      exp_addr = (exp_rdy[c] == 2'b01) ? 32'h10 : 32'h20;
      #1;
      n_checks++; if (m_req_ready !== exp_rdy[c]) begin n_fail++; $display("FAIL prio_rdy c%0d got=%b exp=%b", c, m_req_ready, exp_rdy[c]); end
      n_checks++; if (s_req.addr !== exp_addr) begin n_fail++; $display("FAIL prio_addr c%0d got=%h exp=%h", c, s_req.addr, exp_addr); end
      n_checks++; if (m_rsp_valid !== exp_rsp[c]) begin n_fail++; $display("FAIL prio_rsp c%0d got=%b exp=%b", c, m_rsp_valid, exp_rsp[c]); end
      tick();
    end
    m_req_valid = 2'b10;
    #1;
    n_checks++; if (m_req_ready !== 2'b10) begin n_fail++; $display("FAIL prio_m1_rdy got=%b exp=10", m_req_ready); end
    n_checks++; if (s_req.addr !== 32'h20) begin n_fail++; $display("FAIL prio_m1_addr got=%h exp=00000020", s_req.addr); end
    tick();
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    m_req[0] = '{addr: 32'h44, data: 32'h0, strobe: 4'hF, write: 1'b0};
    m_req[1] = '{addr: 32'h100, data: 32'h5, strobe: 4'h3, write: 1'b1};
    m_req_valid = 2'b10;
    s_req_ready = 1'b0;
    m_rsp_ready = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (s_req_valid !== 1'b1) begin n_fail++; $display("FAIL lock_vld c%0d got=%b exp=1", c, s_req_valid); end
      n_checks++; if (s_req.addr !== 32'h100) begin n_fail++; $display("FAIL lock_addr c%0d got=%h exp=00000100", c, s_req.addr); end
      n_checks++; if (m_req_ready !== 2'b00) begin n_fail++; $display("FAIL lock_rdy c%0d got=%b exp=00", c, m_req_ready); end
      tick();
    end
    m_req_valid = 2'b11;
    #1;
    n_checks++; if (s_req.addr !== 32'h100) begin n_fail++; $display("FAIL lock_hold_addr got=%h exp=00000100", s_req.addr); end
    tick();
    s_req_ready = 1'b1;
    #1;
    n_checks++; if (s_req.addr !== 32'h100) begin n_fail++; $display("FAIL lock_hs_addr got=%h exp=00000100", s_req.addr); end
    n_checks++; if (m_req_ready !== 2'b10) begin n_fail++; $display("FAIL lock_hs_rdy got=%b exp=10", m_req_ready); end
    tick();
    m_req_valid = 2'b01;
    #1;
    n_checks++; if (s_req.addr !== 32'h44) begin n_fail++; $display("FAIL lock_next_addr got=%h exp=00000044", s_req.addr); end
    n_checks++; if (m_req_ready !== 2'b01) begin n_fail++; $display("FAIL lock_next_rdy got=%b exp=01", m_req_ready); end
    tick();
    idle_inputs();
  endtask

  task automatic test_outstanding();
    do_reset();
    m_req[0] = '{addr: 32'h10, data: 32'h0, strobe: 4'hF, write: 1'b0};
    m_req[1] = '{addr: 32'h20, data: 32'h0, strobe: 4'hF, write: 1'b0};
    s_req_ready = 1'b1;
    m_rsp_ready = 2'b11;
    m_req_valid = 2'b01;
    #1;
    n_checks++; if (m_req_ready !== 2'b01) begin n_fail++; $display("FAIL out_m0_rdy got=%b exp=01", m_req_ready); end
    tick();
    m_req_valid = 2'b10;
    #1;
    n_checks++; if (m_req_ready !== 2'b10) begin n_fail++; $display("FAIL out_m1_rdy got=%b exp=10", m_req_ready); end
    tick();
    m_req_valid = 2'b01;
    s_rsp       = '{data: 32'hAAAA, err: 1'b0};
    s_rsp_valid = 1'b1;
    #1;
    n_checks++; if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL out_full_vld got=%b exp=0", s_req_valid); end
    n_checks++; if (m_req_ready !== 2'b00) begin n_fail++; $display("FAIL out_full_rdy got=%b exp=00", m_req_ready); end
    n_checks++; if (m_rsp_valid !== 2'b01) begin n_fail++; $display("FAIL out_rspA_vld got=%b exp=01", m_rsp_valid); end
    n_checks++; if (m_rsp[0].data !== 32'hAAAA) begin n_fail++; $display("FAIL out_rspA_dat got=%h exp=0000aaaa", m_rsp[0].data); end
    n_checks++; if (s_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL out_rspA_rdy got=%b exp=1", s_rsp_ready); end
    tick();
    s_rsp.data = 32'hBBBB;
    #1;
    n_checks++; if (s_req_valid !== 1'b1) begin n_fail++; $display("FAIL out_clear_vld got=%b exp=1", s_req_valid); end
    n_checks++; if (m_req_ready !== 2'b01) begin n_fail++; $display("FAIL out_clear_rdy got=%b exp=01", m_req_ready); end
    n_checks++; if (m_rsp_valid !== 2'b10) begin n_fail++; $display("FAIL out_rspB_vld got=%b exp=10", m_rsp_valid); end
    n_checks++; if (m_rsp[1].data !== 32'hBBBB) begin n_fail++; $display("FAIL out_rspB_dat got=%h exp=0000bbbb", m_rsp[1].data); end
    tick();
    idle_inputs();
  endtask

  task automatic test_rsp_backpressure();
    do_reset();
    m_req[1] = '{addr: 32'h300, data: 32'h0, strobe: 4'hF, write: 1'b0};
    m_req_valid = 2'b10;
    s_req_ready = 1'b1;
    #1;
    n_checks++; if (m_req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_push_rdy got=%b exp=10", m_req_ready); end
    tick();
    m_req_valid = 2'b00;
    s_rsp       = '{data: 32'hCAFE, err: 1'b1};
    s_rsp_valid = 1'b1;
    m_rsp_ready = 2'b01;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (s_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_rdy c%0d got=%b exp=0", c, s_rsp_ready); end
      n_checks++; if (m_rsp_valid !== 2'b10) begin n_fail++; $display("FAIL bp_stall_vld c%0d got=%b exp=10", c, m_rsp_valid); end
      tick();
    end
    m_rsp_ready = 2'b10;
    #1;
    n_checks++; if (s_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL bp_go_rdy got=%b exp=1", s_rsp_ready); end
    n_checks++; if (m_rsp[1].err !== 1'b1) begin n_fail++; $display("FAIL bp_go_err got=%b exp=1", m_rsp[1].err); end
    tick();
    s_rsp_valid = 1'b0;
    m_rsp_ready = 2'b00;
    #1;
    n_checks++; if (s_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL bp_drained got=%b exp=1", s_rsp_ready); end
    n_checks++; if (spurious !== 1'b0) begin n_fail++; $display("FAIL bp_spurious got=%b exp=0", spurious); end
    idle_inputs();
  endtask

  task automatic test_spurious();
    do_reset();
    s_rsp       = '{data: 32'hDEAD, err: 1'b0};
    s_rsp_valid = 1'b1;
    m_rsp_ready = 2'b00;
    #1;
    n_checks++; if (s_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL spur_rdy got=%b exp=1", s_rsp_ready); end
    n_checks++; if (m_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL spur_vld got=%b exp=00", m_rsp_valid); end
    n_checks++; if (spurious !== 1'b0) begin n_fail++; $display("FAIL spur_pre got=%b exp=0", spurious); end
    tick();
    s_rsp_valid = 1'b0;
    #1;
    n_checks++; if (spurious !== 1'b1) begin n_fail++; $display("FAIL spur_set got=%b exp=1", spurious); end
    tick();
    tick();
    n_checks++; if (spurious !== 1'b1) begin n_fail++; $display("FAIL spur_sticky got=%b exp=1", spurious); end
    rst = 1'b1;
    tick();
    n_checks++; if (spurious !== 1'b0) begin n_fail++; $display("FAIL spur_clear got=%b exp=0", spurious); end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_req[0] = '0;
    m_req[1] = '0;
    test_reset();
    test_priority();
    test_lock();
    test_outstanding();
    test_rsp_backpressure();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
